ff_t: RTL and testbench



---
 rtl/ff_t_if.sv | 25 ++
 rtl/ff_t.sv | 33 +++
 tb/tb_ff_t.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/ff_t_if.sv
// Purpose: bundles the control, data and state signals of the ff_t toggle flip-flop bank.
// Latency: none; wiring only.
// Backpressure: none; these are plain level signals with no handshake.
interface ff_t_if #(
  parameter int WIDTH = 1
);
  logic             en;
  logic             ld;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] T;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] Qn;

  // The stimulus side drives the controls and watches the state.
  modport master (
    output en, ld, d, T,
    input  Q, Qn
  );

  // The flip-flop bank consumes the controls and produces the state.
  modport slave (
    input  en, ld, d, T,
    output Q, Qn
  );
endinterface

// File: rtl/ff_t.sv
// Purpose: bank of WIDTH independent T flip-flops with reset, clock enable and parallel load; Qn = ~Q.
// Latency: one clk edge from sampled inputs to Q; Qn follows Q combinationally.
// Backpressure: none; every edge is consumed, and en=0 simply freezes the state.
module ff_t #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic  clk,
  input  logic  rst,
  ff_t_if.slave bus
);

  // The initializer gives simulation a defined value before the first reset;
  // hardware relies on rst for its starting value.
  logic [WIDTH-1:0] q_r = RESET_VAL;

  // State update, highest priority first: reset, enable, load, toggle.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r <= RESET_VAL;
    end else if (bus.en) begin
      if (bus.ld) begin
        q_r <= bus.d;
      end else begin
        q_r <= q_r ^ bus.T;
      end
    end
  end

  assign bus.Q  = q_r;
  assign bus.Qn = ~q_r;

endmodule

// File: tb/tb_ff_t.sv
module tb_ff_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1;
  logic rst8;

  ff_t_if #(.WIDTH(1)) if1 ();
  ff_t_if #(.WIDTH(8)) if8 ();

  ff_t #(.WIDTH(1)) u_ff1 (
    .clk (clk),
    .rst (rst1),
    .bus (if1)
  );

  ff_t #(.WIDTH(8), .RESET_VAL(8'h3C)) u_ff8 (
    .clk (clk),
    .rst (rst8),
    .bus (if8)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic       m1;
  logic [7:0] m8;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference behaviour straight from the priority list.
  function automatic logic [7:0] model(input logic [7:0] q, input bit r, input bit e, input bit l,
                                       input logic [7:0] dd, input logic [7:0] tt);
    logic [7:0] nq;
    nq = q;
    if (r) nq = 8'h3C;
    else if (!e) nq = q;
    else if (l) nq = dd;
    else begin
      for (int i = 0; i < 8; i++)
        if (tt[i]) nq[i] = !q[i];
    end
    return nq;
  endfunction

  task automatic drive1(input bit r, input bit e, input bit l, input bit dd, input bit tt);
    logic [7:0] tmp;
    @(negedge clk);
    rst1 = r; if1.en = e; if1.ld = l; if1.d = dd; if1.T = tt;
    if (r) tmp = 8'h00;
    else tmp = model({7'b0, m1}, 1'b0, e, l, {7'b0, dd}, {7'b0, tt});
    m1 = tmp[0];
    @(posedge clk);
    #1;
  endtask

  task automatic drive8(input bit r, input bit e, input bit l, input logic [7:0] dd, input logic [7:0] tt);
    @(negedge clk);
    rst8 = r; if8.en = e; if8.ld = l; if8.d = dd; if8.T = tt;
    m8 = model(m8, r, e, l, dd, tt);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst1 = 1'b0; if1.en = 1'b0; if1.ld = 1'b0; if1.d = 1'b0; if1.T = 1'b0;
    rst8 = 1'b0; if8.en = 1'b0; if8.ld = 1'b0; if8.d = 8'h00; if8.T = 8'h00;
    m1 = 1'b0;
    m8 = 8'h3C;

    // Power-up value before any reset.
    #1;
    check("pwrup_q1",  if1.Q,  64'h0);
    check("pwrup_qn1", if1.Qn, 64'h1);
    check("pwrup_q8",  if8.Q,  64'h3C);
    check("pwrup_qn8", if8.Qn, 64'hC3);

    // Basic toggle on the single-bit bank.
    drive1(1, 1, 0, 0, 0); check("rst_q1", if1.Q, 64'h0); check("rst_qn1", if1.Qn, 64'h1);
    drive1(0, 1, 0, 0, 1); check("tog1_q", if1.Q, 64'h1); check("tog1_qn", if1.Qn, 64'h0);
    drive1(0, 1, 0, 0, 0); check("hold1_q", if1.Q, 64'h1);
    drive1(0, 1, 0, 0, 1); check("tog2_q", if1.Q, 64'h0);
    drive1(0, 1, 0, 0, 0); check("hold2_q", if1.Q, 64'h0);

    // Continuous toggle: clk/2 square wave starting from Q=0.
    for (int i = 0; i < 8; i++) begin
      drive1(0, 1, 0, 0, 1);
      check("div2_q",  if1.Q,  (i % 2 == 0) ? 64'h1 : 64'h0);
      check("div2_qn", if1.Qn, (i % 2 == 0) ? 64'h0 : 64'h1);
    end

    // Reset beats load and toggle; release resumes toggling.
    drive1(0, 1, 0, 0, 1); check("pre_rst_q", if1.Q, 64'h1);
    drive1(1, 1, 1, 1, 1); check("rstpri_q", if1.Q, 64'h0); check("rstpri_qn", if1.Qn, 64'h1);
    drive1(0, 1, 0, 0, 1); check("post_rst_q", if1.Q, 64'h1);

    // Eight-bit bank with a non-zero reset value.
    drive8(1, 1, 0, 8'h00, 8'h00); check("rst8_q", if8.Q, 64'h3C); check("rst8_qn", if8.Qn, 64'hC3);
    drive8(0, 1, 0, 8'h00, 8'h81); check("tog81_q", if8.Q, 64'hBD);
    drive8(0, 0, 0, 8'h00, 8'hFF); check("en0_q", if8.Q, 64'hBD);
    drive8(0, 1, 1, 8'hA5, 8'hFF); check("ld_q", if8.Q, 64'hA5);
    drive8(0, 1, 0, 8'h00, 8'h0F); check("tog0f_q", if8.Q, 64'hAA); check("tog0f_qn", if8.Qn, 64'h55);

    // Unknown controls under reset must not reach Q.
    @(negedge clk);
    rst8 = 1'b1; if8.en = 1'bx; if8.ld = 1'bx; if8.d = 8'hxx; if8.T = 8'hxx;
    @(posedge clk);
    #1;
    m8 = 8'h3C;
    check("rstx_q", if8.Q, 64'h3C);
    check("rstx_qn", if8.Qn, 64'hC3);

    // Random run on both banks against the reference model.
    for (int n = 0; n < 400; n++) begin
      bit         r1, e1, l1, d1, t1;
      bit         r8, e8, l8;
      logic [7:0] dd8, tt8, tmp;
      r1 = ($urandom_range(15) == 0); e1 = ($urandom_range(3) != 0); l1 = ($urandom_range(7) == 0);
      d1 = 1'($urandom); t1 = 1'($urandom);
      r8 = ($urandom_range(15) == 0); e8 = ($urandom_range(3) != 0); l8 = ($urandom_range(7) == 0);
      dd8 = 8'($urandom); tt8 = 8'($urandom);
      @(negedge clk);
      rst1 = r1; if1.en = e1; if1.ld = l1; if1.d = d1; if1.T = t1;
      rst8 = r8; if8.en = e8; if8.ld = l8; if8.d = dd8; if8.T = tt8;
      if (r1) tmp = 8'h00;
      else tmp = model({7'b0, m1}, 1'b0, e1, l1, {7'b0, d1}, {7'b0, t1});
      m1 = tmp[0];
      m8 = model(m8, r8, e8, l8, dd8, tt8);
      @(posedge clk);
      #1;
      check("rnd_q1",  if1.Q,  {63'b0, m1});
      check("rnd_qn1", if1.Qn, {63'b0, ~m1});
      check("rnd_q8",  if8.Q,  {56'b0, m8});
      check("rnd_qn8", if8.Qn, {56'b0, ~m8});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
